// File: rtl/rle_rec_pkg.sv
// Shared types and width helpers for the run-length key recorder.
// Default widths describe the standard two-buzzer build.
package rle_rec_pkg;

  localparam int KEY_W_DEF  = 7;
  localparam int CNT_W_DEF  = 16;
  localparam int DEPTH_DEF  = 64;
  localparam int NUM_CH_DEF = 2;

  // Width of an index over n items, never narrower than one bit.
  function automatic int bitsFor(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = bitsFor(DEPTH_DEF);
  localparam int LEN_W = $clog2(DEPTH_DEF + 1);
  localparam int CH_W  = bitsFor(NUM_CH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REC,
    ST_PLAY_FETCH,
    ST_PLAY_RUN
  } rec_state_e;

  typedef struct packed {
    logic [KEY_W_DEF-1:0] key;
    logic [CNT_W_DEF-1:0] cnt;
  } rle_entry_t;

endpackage

// File: rtl/rle_entry_ram.sv
// Single-port run storage: one write or one registered read per cycle.
module rle_entry_ram #(
  parameter int WIDTH   = 23,
  parameter int ENTRIES = 128,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end else begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/rle_key_recorder.sv
// Records the ticked key stream as {key, count} runs per channel and
// replays a chosen channel's runs onto key_out, once or looped.
module rle_key_recorder
  import rle_rec_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [KEY_W-1:0]              key_in,
  input  logic [bitsFor(NUM_CH)-1:0]    ch_sel,
  input  logic                          rec_start,
  input  logic                          play_start,
  input  logic                          stop,
  input  logic                          loop_en,
  output logic [KEY_W-1:0]              key_out,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          full,
  output logic                          done,
  output logic [$clog2(DEPTH+1)-1:0]    len_out
);

  localparam int CH_BITS   = bitsFor(NUM_CH);
  localparam int PTR_BITS  = bitsFor(DEPTH);
  localparam int LEN_BITS  = $clog2(DEPTH + 1);
  localparam int ENTRIES   = NUM_CH * DEPTH;
  localparam int ADDR_BITS = bitsFor(ENTRIES);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(DEPTH - 1);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  rec_state_e            state_q, state_d;
  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic [PTR_BITS-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_BITS-1:0]   rdPtr_q, rdPtr_d;
  logic                  haveRun_q, haveRun_d;
  logic [KEY_W-1:0]      curKey_q, curKey_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tickPend_q, tickPend_d;
  logic [KEY_W-1:0]      keyOut_q, keyOut_d;
  logic                  keyValid_q, keyValid_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic [LEN_BITS-1:0]   len_q [NUM_CH];
  logic [LEN_BITS-1:0]   len_d [NUM_CH];

  logic                  ramWe;
  logic [ADDR_BITS-1:0]  ramAddr;
  entry_t                ramWdata;
  entry_t                ramRdata;

  function automatic logic [ADDR_BITS-1:0] entryAddr(input logic [CH_BITS-1:0]  ch,
                                                     input logic [PTR_BITS-1:0] ptr);
    return ADDR_BITS'(ch) * ADDR_BITS'(DEPTH) + ADDR_BITS'(ptr);
  endfunction

  rle_entry_ram #(
    .WIDTH  (KEY_W + CNT_W),
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_BITS)
  ) u_ram (
    .clk    (clk),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(ramWdata),
    .rdata_o(ramRdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      haveRun_q  <= 1'b0;
      curKey_q   <= '0;
      cnt_q      <= '0;
      tickPend_q <= 1'b0;
      keyOut_q   <= '0;
      keyValid_q <= 1'b0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) len_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      haveRun_q  <= haveRun_d;
      curKey_q   <= curKey_d;
      cnt_q      <= cnt_d;
      tickPend_q <= tickPend_d;
      keyOut_q   <= keyOut_d;
      keyValid_q <= keyValid_d;
      full_q     <= full_d;
      done_q     <= done_d;
      len_q      <= len_d;
    end
  end

  // cnt_q is the growing run length while recording and the ticks left while playing.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    haveRun_d  = haveRun_q;
    curKey_d   = curKey_q;
    cnt_d      = cnt_q;
    tickPend_d = tickPend_q;
    keyOut_d   = keyOut_q;
    keyValid_d = keyValid_q;
    full_d     = full_q;
    done_d     = 1'b0;
    len_d      = len_q;
    ramWe      = 1'b0;
    ramWdata   = '{key: curKey_q, cnt: cnt_q};

    case (state_q)
      ST_IDLE: begin
        if (rec_start) begin
          state_d   = ST_REC;
          ch_d      = ch_sel;
          wrPtr_d   = '0;
          haveRun_d = 1'b0;
          full_d    = 1'b0;
        end else if (play_start && (len_q[ch_sel] != '0)) begin
          state_d    = ST_PLAY_FETCH;
          ch_d       = ch_sel;
          rdPtr_d    = '0;
          tickPend_d = 1'b0;
        end
      end

      ST_REC: begin
        if (stop) begin
          state_d   = ST_IDLE;
          haveRun_d = 1'b0;
          if (haveRun_q) begin
            ramWe       = 1'b1;
            len_d[ch_q] = LEN_BITS'(wrPtr_q) + LEN_BITS'(1);
            if (wrPtr_q == LAST_PTR) full_d = 1'b1;
          end else begin
            len_d[ch_q] = LEN_BITS'(wrPtr_q);
          end
        end else if (tick) begin
          if (!haveRun_q) begin
            curKey_d  = key_in;
            cnt_d     = CNT_W'(1);
            haveRun_d = 1'b1;
          end else if ((key_in == curKey_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // Filling the last slot ends the take; the run just begun is dropped.
            ramWe = 1'b1;
            if (wrPtr_q == LAST_PTR) begin
              len_d[ch_q] = LEN_BITS'(DEPTH);
              full_d      = 1'b1;
              haveRun_d   = 1'b0;
              state_d     = ST_IDLE;
            end else begin
              wrPtr_d  = wrPtr_q + PTR_BITS'(1);
              curKey_d = key_in;
              cnt_d    = CNT_W'(1);
            end
          end
        end
      end

      ST_PLAY_FETCH: begin
        if (stop) begin
          state_d    = ST_IDLE;
          keyOut_d   = '0;
          keyValid_d = 1'b0;
          tickPend_d = 1'b0;
        end else begin
          if (tick) tickPend_d = 1'b1;
          state_d    = ST_PLAY_RUN;
          keyOut_d   = ramRdata.key;
          cnt_d      = ramRdata.cnt;
          keyValid_d = 1'b1;
        end
      end

      ST_PLAY_RUN: begin
        if (stop) begin
          state_d    = ST_IDLE;
          keyOut_d   = '0;
          keyValid_d = 1'b0;
          tickPend_d = 1'b0;
        end else if (tick || tickPend_q) begin
          tickPend_d = 1'b0;
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if ((LEN_BITS'(rdPtr_q) + LEN_BITS'(1)) < len_q[ch_q]) begin
            rdPtr_d = rdPtr_q + PTR_BITS'(1);
            state_d = ST_PLAY_FETCH;
          end else if (loop_en) begin
            rdPtr_d = '0;
            state_d = ST_PLAY_FETCH;
          end else begin
            done_d     = 1'b1;
            keyOut_d   = '0;
            keyValid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
    endcase

    // Reads are aimed at the next pointer so the entry is ready during PLAY_FETCH.
    ramAddr = entryAddr(ch_d, ramWe ? wrPtr_q : rdPtr_d);
  end

  assign key_out   = keyOut_q;
  assign key_valid = keyValid_q;
  assign busy      = (state_q != ST_IDLE);
  assign full      = full_q;
  assign done      = done_q;
  assign len_out   = len_q[ch_sel];

endmodule

// File: tb/tb_rle_key_recorder.sv
// Directed bench: default build driven from a vector table, plus small
// builds for counter saturation, the full-memory cutoff and reset abort.
module tb_rle_key_recorder;

  localparam int KW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          stop = 1'b0;
  logic          loopEn = 1'b0;
  logic [KW-1:0] keyIn = '0;
  logic          chSel = 1'b0;
  logic [2:0]    recStart = '0;
  logic [2:0]    playStart = '0;

  logic [KW-1:0] keyA, keyC, keyD;
  logic          validA, validC, validD;
  logic          busyA, busyC, busyD;
  logic          fullA, fullC, fullD;
  logic          doneA, doneC, doneD;
  logic [6:0]    lenA, lenC;
  logic [2:0]    lenD;

  int checks = 0;
  int errors = 0;
  int doneCntA = 0, doneCntC = 0, doneCntD = 0;

  typedef struct {
    bit rec, play, tk, stp, loopEn, ch;
    int key, expKey, expValid, expBusy, expLen, expDone;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (doneA === 1'b1) doneCntA <= doneCntA + 1;
    if (doneC === 1'b1) doneCntC <= doneCntC + 1;
    if (doneD === 1'b1) doneCntD <= doneCntD + 1;
  end

  rle_key_recorder #(.KEY_W(7), .CNT_W(16), .DEPTH(64), .NUM_CH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(keyIn), .ch_sel(chSel),
    .rec_start(recStart[0]), .play_start(playStart[0]), .stop(stop), .loop_en(loopEn),
    .key_out(keyA), .key_valid(validA), .busy(busyA), .full(fullA), .done(doneA), .len_out(lenA)
  );

  rle_key_recorder #(.KEY_W(7), .CNT_W(4), .DEPTH(64), .NUM_CH(2)) dutC (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(keyIn), .ch_sel(chSel),
    .rec_start(recStart[1]), .play_start(playStart[1]), .stop(stop), .loop_en(loopEn),
    .key_out(keyC), .key_valid(validC), .busy(busyC), .full(fullC), .done(doneC), .len_out(lenC)
  );

  rle_key_recorder #(.KEY_W(7), .CNT_W(16), .DEPTH(4), .NUM_CH(2)) dutD (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_in(keyIn), .ch_sel(chSel),
    .rec_start(recStart[2]), .play_start(playStart[2]), .stop(stop), .loop_en(loopEn),
    .key_out(keyD), .key_valid(validD), .busy(busyD), .full(fullD), .done(doneD), .len_out(lenD)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One input cycle, then three quiet cycles; keeps ticks four clocks apart.
  task automatic driveStep(input logic [2:0] rec, input logic [2:0] play,
                           input logic tk, input logic stp, input logic [KW-1:0] key);
    recStart  = rec;
    playStart = play;
    tick      = tk;
    stop      = stp;
    keyIn     = key;
    @(posedge clk); #1;
    recStart  = '0;
    playStart = '0;
    tick      = 1'b0;
    stop      = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic addVec(input bit rec, input bit play, input bit tk, input bit stp,
                        input bit le, input bit ch, input int key, input int expKey,
                        input int expValid, input int expBusy, input int expLen, input int expDone);
    vec_t v;
    v.rec = rec; v.play = play; v.tk = tk; v.stp = stp; v.loopEn = le; v.ch = ch;
    v.key = key; v.expKey = expKey; v.expValid = expValid; v.expBusy = expBusy;
    v.expLen = expLen; v.expDone = expDone;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int d0;
    loopEn = v.loopEn;
    chSel  = v.ch;
    d0     = doneCntA;
    driveStep({2'b00, v.rec}, {2'b00, v.play}, v.tk, v.stp, KW'(v.key));
    checkOutput($sformatf("vec%0d key_out", idx), keyA, v.expKey);
    checkOutput($sformatf("vec%0d key_valid", idx), validA, v.expValid);
    checkOutput($sformatf("vec%0d busy", idx), busyA, v.expBusy);
    checkOutput($sformatf("vec%0d len_out", idx), lenA, v.expLen);
    checkOutput($sformatf("vec%0d done_pulses", idx), doneCntA - d0, v.expDone);
  endtask

  // Replays ch0 holding {65,3},{67,2}: key seen before each of five ticks, then done.
  task automatic addCase1Play(input bit ch);
    addVec(0,1,0,0,0,ch, 0, 65,1,1,2,0);
    addVec(0,0,1,0,0,ch, 0, 65,1,1,2,0);
    addVec(0,0,1,0,0,ch, 0, 65,1,1,2,0);
    addVec(0,0,1,0,0,ch, 0, 67,1,1,2,0);
    addVec(0,0,1,0,0,ch, 0, 67,1,1,2,0);
    addVec(0,0,1,0,0,ch, 0,  0,0,0,2,1);
  endtask

  initial begin
    int d0;

    // rec play tk stp loop ch key | key valid busy len done
    addVec(1,0,0,0,0,0, 0,  0,0,1,0,0);
    addVec(0,0,1,0,0,0,65,  0,0,1,0,0);
    addVec(0,0,1,0,0,0,65,  0,0,1,0,0);
    addVec(0,0,1,0,0,0,65,  0,0,1,0,0);
    addVec(0,0,1,0,0,0,67,  0,0,1,0,0);
    addVec(0,0,1,0,0,0,67,  0,0,1,0,0);
    addVec(0,0,0,1,0,0, 0,  0,0,0,2,0);
    addCase1Play(1'b0);
    addVec(1,0,0,0,0,1, 0,  0,0,1,0,0);
    addVec(0,0,1,0,0,1,70,  0,0,1,0,0);
    addVec(0,0,1,0,0,1,70,  0,0,1,0,0);
    addVec(0,0,1,0,0,1,70,  0,0,1,0,0);
    addVec(0,0,1,0,0,1,70,  0,0,1,0,0);
    addVec(0,0,0,1,0,1, 0,  0,0,0,1,0);
    addCase1Play(1'b0);
    addVec(0,0,0,0,0,1, 0,  0,0,0,1,0);
    addVec(0,1,0,0,0,1, 0, 70,1,1,1,0);
    addVec(0,0,1,0,0,1, 0, 70,1,1,1,0);
    addVec(0,0,1,0,0,1, 0, 70,1,1,1,0);
    addVec(0,0,1,0,0,1, 0, 70,1,1,1,0);
    addVec(0,0,1,0,0,1, 0,  0,0,0,1,1);
    addVec(0,1,0,0,1,0, 0, 65,1,1,2,0);
    addVec(0,0,1,0,1,0, 0, 65,1,1,2,0);
    addVec(1,0,1,0,1,0, 0, 65,1,1,2,0);
    addVec(0,0,1,0,1,0, 0, 67,1,1,2,0);
    addVec(0,0,1,0,1,0, 0, 67,1,1,2,0);
    addVec(0,0,1,0,1,0, 0, 65,1,1,2,0);
    addVec(0,0,1,0,1,0, 0, 65,1,1,2,0);
    addVec(0,0,1,0,1,0, 0, 65,1,1,2,0);
    addVec(0,0,1,0,0,0, 0, 67,1,1,2,0);
    addVec(0,0,1,0,0,0, 0, 67,1,1,2,0);
    addVec(0,0,1,0,0,0, 0,  0,0,0,2,1);
    addVec(1,1,0,0,0,1, 0,  0,0,1,1,0);
    addVec(0,0,0,1,0,1, 0,  0,0,0,0,0);
    addVec(0,1,0,0,0,1, 0,  0,0,0,0,0);
    addVec(0,0,0,0,0,0, 0,  0,0,0,2,0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset key_out", keyA, 0);
    checkOutput("reset key_valid", validA, 0);
    checkOutput("reset busy", busyA, 0);
    checkOutput("reset full", fullA, 0);
    checkOutput("reset done", doneA, 0);
    checkOutput("reset len_out", lenA, 0);
    checkOutput("reset busyC", busyC, 0);
    checkOutput("reset busyD", busyD, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] vector table: %0d steps", vecs.size());
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    $display("[TB] counter saturation with CNT_W=4");
    chSel  = 1'b0;
    loopEn = 1'b0;
    driveStep(3'b010, 3'b000, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) driveStep(3'b000, 3'b000, 1'b1, 1'b0, 7'd65);
    driveStep(3'b000, 3'b000, 1'b0, 1'b1, '0);
    checkOutput("sat len_out", lenC, 2);
    checkOutput("sat full", fullC, 0);
    checkOutput("sat busy idle", busyC, 0);
    d0 = doneCntC;
    driveStep(3'b000, 3'b010, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("sat play%0d {valid,key}", i), {validC, keyC}, {1'b1, 7'd65});
      driveStep(3'b000, 3'b000, 1'b1, 1'b0, '0);
    end
    checkOutput("sat done_pulses", doneCntC - d0, 1);
    checkOutput("sat valid end", validC, 0);
    checkOutput("sat busy end", busyC, 0);

    $display("[TB] full cutoff with DEPTH=4");
    driveStep(3'b100, 3'b000, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      driveStep(3'b000, 3'b000, 1'b1, 1'b0, (i % 2 == 0) ? 7'd65 : 7'd66);
      if (i == 3) begin
        checkOutput("depth full before 4th write", fullD, 0);
        checkOutput("depth busy before 4th write", busyD, 1);
      end
      if (i == 4) begin
        checkOutput("depth full at 4th write", fullD, 1);
        checkOutput("depth busy at 4th write", busyD, 0);
        checkOutput("depth len at 4th write", lenD, 4);
      end
    end
    driveStep(3'b000, 3'b000, 1'b0, 1'b1, '0);
    checkOutput("depth full after stop", fullD, 1);
    checkOutput("depth busy after stop", busyD, 0);
    checkOutput("depth len after stop", lenD, 4);
    d0 = doneCntD;
    driveStep(3'b000, 3'b100, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("depth play%0d key", i), keyD, (i % 2 == 0) ? 65 : 66);
      driveStep(3'b000, 3'b000, 1'b1, 1'b0, '0);
    end
    checkOutput("depth play valid end", validD, 0);
    checkOutput("depth done_pulses", doneCntD - d0, 1);
    driveStep(3'b100, 3'b000, 1'b0, 1'b0, '0);
    checkOutput("depth full cleared on rec", fullD, 0);
    checkOutput("depth busy on rec", busyD, 1);
    driveStep(3'b000, 3'b000, 1'b0, 1'b1, '0);
    checkOutput("depth empty take len", lenD, 0);

    $display("[TB] reset during playback");
    chSel = 1'b0;
    driveStep(3'b000, 3'b001, 1'b0, 1'b0, '0);
    checkOutput("abort play key", keyA, 65);
    driveStep(3'b000, 3'b000, 1'b1, 1'b0, '0);
    checkOutput("abort play key after tick", keyA, 65);
    checkOutput("abort play valid after tick", validA, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort key_out", keyA, 0);
    checkOutput("abort key_valid", validA, 0);
    checkOutput("abort busy", busyA, 0);
    checkOutput("abort len ch0", lenA, 0);
    chSel = 1'b1;
    #1;
    checkOutput("abort len ch1", lenA, 0);
    chSel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    driveStep(3'b000, 3'b001, 1'b0, 1'b0, '0);
    checkOutput("post-reset play busy", busyA, 0);
    checkOutput("post-reset play valid", validA, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
